// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, transmitter
// state encoding and bit-period helpers.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Width of a counter that must hold div-1; never narrower than one bit.
   function automatic int calc_cnt_w(input int div);
      return ($clog2(div) < 1) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake and serial output of the configurable UART
// transmitter.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 data_en;
   logic                 busy;
   logic                 tx_out;
   logic                 tx_done;

   modport master (
      output data,
      output data_en,
      input  busy,
      input  tx_out,
      input  tx_done
   );

   modport slave (
      input  data,
      input  data_en,
      output busy,
      output tx_out,
      output tx_done
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: bit_end is high while the count is zero, then the
// counter wraps to DIV-1. A restart reloads DIV-1 so a new bit starts aligned.
module uart_baud_gen #(
   parameter int DIV   = 10,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_end
);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (restart || (cnt_reg == '0)) begin
         cnt_reg <= RELOAD;
      end else begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign bit_end = (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits, every bit DIV clocks long.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input logic         clk,
   input logic         rst,
   uart_tx_cfg_if.slave bus
);
   localparam int DIV   = calc_div(CLK_FREQ, BAUD);
   localparam int CNT_W = calc_cnt_w(DIV);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic       ODD_FLIP  = (PARITY == PAR_ODD);

   tx_state_t            state_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_reg;
   logic [3:0]           bit_idx_reg;
   logic                 stop_idx_reg;
   logic                 busy_reg;
   logic                 tx_reg;
   logic                 done_reg;
   logic                 accept;
   logic                 bit_end;

   assign accept = !busy_reg && bus.data_en;

   uart_baud_gen #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .restart (accept),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         bit_idx_reg  <= '0;
         stop_idx_reg <= 1'b0;
         busy_reg     <= 1'b0;
         tx_reg       <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               tx_reg <= 1'b1;
               if (accept) begin
                  // Parity is frozen here so later changes on data cannot leak in.
                  shift_reg  <= bus.data;
                  parity_reg <= (^bus.data) ^ ODD_FLIP;
                  busy_reg   <= 1'b1;
                  tx_reg     <= 1'b0;
                  state_reg  <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_idx_reg <= '0;
                  state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_idx_reg == LAST_DATA) begin
                     if (PARITY != PAR_NONE) begin
                        tx_reg    <= parity_reg;
                        state_reg <= ST_PARITY;
                     end else begin
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                     end
                  end else begin
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx_reg       <= 1'b1;
                  stop_idx_reg <= 1'b0;
                  state_reg    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (stop_idx_reg == LAST_STOP) begin
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     stop_idx_reg <= 1'b1;
                  end
               end
            end
            default: begin
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.tx_out  = tx_reg;
   assign bus.tx_done = done_reg;

endmodule
